// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port byte-wide RAM controller shared by instruction
// fetch (IF) and data access (MEM). MEM has priority over IF. Requests of
// 1, 2 or 4 bytes are serialised little-endian, one byte per cycle. A taken
// jump (flush_i) cancels a pending or in-flight fetch.
module mem_arbiter #(
    parameter int unsigned ADDR_W = 17
) (
    input  logic              clk,
    input  logic              rst,
    // instruction fetch port
    input  logic              if_i,
    input  logic [31:0]       if_pc_i,
    input  logic              flush_i,
    output logic              if_busy_o,
    output logic              if_done_o,
    output logic [31:0]       inst_o,
    // data access port
    input  logic              mem_i,
    input  logic              mem_we_i,
    input  logic [1:0]        mem_len_i,
    input  logic [31:0]       mem_addr_i,
    input  logic [31:0]       mem_wdata_i,
    output logic              mem_busy_o,
    output logic              mem_done_o,
    output logic [31:0]       mem_rdata_o,
    // byte-wide RAM
    output logic [ADDR_W-1:0] ram_a_o,
    output logic [7:0]        ram_dout_o,
    output logic              ram_wr_o,
    input  logic [7:0]        ram_din_i
);

    typedef enum logic [1:0] {
        IDLE,
        IF_RD,
        MEM_RD,
        MEM_WR
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] base;
    logic [2:0]        n_bytes;
    logic [2:0]        cnt;
    logic [31:0]       wdata;
    logic [31:0]       asm_q;
    logic [31:0]       asm_next;
    logic              last;
    logic              if_done_q;
    logic              mem_done_q;
    logic [31:0]       inst_q;
    logic [31:0]       rdata_q;

    // Address bits above ADDR_W are deliberately dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_pc_i[31:ADDR_W], mem_addr_i[31:ADDR_W]};

    // Byte count from the access length code; 10 is treated as a word.
    function automatic logic [2:0] len_to_n(input logic [1:0] len);
        case (len)
            2'b00:   len_to_n = 3'd1;
            2'b01:   len_to_n = 3'd2;
            default: len_to_n = 3'd4;
        endcase
    endfunction

    // Merge the byte arriving this cycle into its little-endian lane.
    always_comb begin
        asm_next = asm_q;
        case (cnt[1:0])
            2'd0:    asm_next[7:0]   = ram_din_i;
            2'd1:    asm_next[15:8]  = ram_din_i;
            2'd2:    asm_next[23:16] = ram_din_i;
            default: asm_next[31:24] = ram_din_i;
        endcase
    end

    assign last = ((cnt + 3'd1) == n_bytes);

    // Arbitration, byte sequencing, data assembly and done pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            base       <= '0;
            n_bytes    <= '0;
            cnt        <= '0;
            wdata      <= '0;
            asm_q      <= '0;
            if_done_q  <= 1'b0;
            mem_done_q <= 1'b0;
            inst_q     <= '0;
            rdata_q    <= '0;
        end else begin
            if_done_q  <= 1'b0;
            mem_done_q <= 1'b0;
            case (state)
                IDLE: begin
                    cnt   <= '0;
                    asm_q <= '0;
                    if (mem_i) begin
                        base    <= mem_addr_i[ADDR_W-1:0];
                        n_bytes <= len_to_n(mem_len_i);
                        wdata   <= mem_wdata_i;
                        state   <= mem_we_i ? MEM_WR : MEM_RD;
                    end else if (if_i && !flush_i) begin
                        base    <= if_pc_i[ADDR_W-1:0];
                        n_bytes <= 3'd4;
                        state   <= IF_RD;
                    end
                end
                IF_RD: begin
                    // A flush abandons the fetch without touching inst_o.
                    if (flush_i) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        asm_q <= asm_next;
                        if (last) begin
                            state     <= IDLE;
                            cnt       <= '0;
                            inst_q    <= asm_next;
                            if_done_q <= 1'b1;
                        end else begin
                            cnt <= cnt + 3'd1;
                        end
                    end
                end
                MEM_RD: begin
                    asm_q <= asm_next;
                    if (last) begin
                        state      <= IDLE;
                        cnt        <= '0;
                        rdata_q    <= asm_next;
                        mem_done_q <= 1'b1;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                MEM_WR: begin
                    if (last) begin
                        state      <= IDLE;
                        cnt        <= '0;
                        mem_done_q <= 1'b1;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign if_done_o   = if_done_q;
    assign mem_done_o  = mem_done_q;
    assign inst_o      = inst_q;
    assign mem_rdata_o = rdata_q;

    assign mem_busy_o  = (state != IDLE);
    assign if_busy_o   = (state != IDLE) || mem_i;

    // RAM address wraps at 2^ADDR_W; write strobe and data only during a store.
    assign ram_a_o    = (state == IDLE) ? '0 : (base + ADDR_W'(cnt));
    assign ram_wr_o   = (state == MEM_WR);
    assign ram_dout_o = (state == MEM_WR) ? wdata[{cnt[1:0], 3'b000} +: 8] : 8'h00;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scenario tasks driving mem_arbiter against a byte-wide RAM
// model; expected read data is queued per port and popped on each done pulse.
module tb_mem_arbiter;

    localparam int unsigned AW = 17;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_i;
    logic [31:0]   if_pc_i;
    logic          flush_i;
    logic          if_busy_o;
    logic          if_done_o;
    logic [31:0]   inst_o;
    logic          mem_i;
    logic          mem_we_i;
    logic [1:0]    mem_len_i;
    logic [31:0]   mem_addr_i;
    logic [31:0]   mem_wdata_i;
    logic          mem_busy_o;
    logic          mem_done_o;
    logic [31:0]   mem_rdata_o;
    logic [AW-1:0] ram_a_o;
    logic [7:0]    ram_dout_o;
    logic          ram_wr_o;
    logic [7:0]    ram_din_i;

    int checks = 0;
    int passed = 0;

    logic [31:0] if_q[$];
    logic [31:0] mem_q[$];

    always #5 clk = ~clk;

    // RAM model: read data follows the presented address, writes on the edge.
    logic [7:0] ram [0:(1<<AW)-1];
    assign ram_din_i = ram[ram_a_o];
    always @(posedge clk) if (ram_wr_o) ram[ram_a_o] <= ram_dout_o;

    mem_arbiter #(.ADDR_W(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .if_i       (if_i),
        .if_pc_i    (if_pc_i),
        .flush_i    (flush_i),
        .if_busy_o  (if_busy_o),
        .if_done_o  (if_done_o),
        .inst_o     (inst_o),
        .mem_i      (mem_i),
        .mem_we_i   (mem_we_i),
        .mem_len_i  (mem_len_i),
        .mem_addr_i (mem_addr_i),
        .mem_wdata_i(mem_wdata_i),
        .mem_busy_o (mem_busy_o),
        .mem_done_o (mem_done_o),
        .mem_rdata_o(mem_rdata_o),
        .ram_a_o    (ram_a_o),
        .ram_dout_o (ram_dout_o),
        .ram_wr_o   (ram_wr_o),
        .ram_din_i  (ram_din_i)
    );

    task automatic idle_inputs();
        if_i        = 1'b0;
        if_pc_i     = '0;
        flush_i     = 1'b0;
        mem_i       = 1'b0;
        mem_we_i    = 1'b0;
        mem_len_i   = 2'b00;
        mem_addr_i  = '0;
        mem_wdata_i = '0;
    endtask

    task automatic test_reset();
        logic [102:0] outs;
        rst = 1'b0;
        idle_inputs();
        repeat (3) @(negedge clk);
        outs = {if_busy_o, if_done_o, inst_o, mem_busy_o, mem_done_o, mem_rdata_o,
                ram_a_o, ram_dout_o, ram_wr_o};
        checks++;
        if (outs !== '0) $display("FAIL reset_outputs: got %h expected 0", outs);
        else passed++;
        rst = 1'b1;
        @(negedge clk);
        outs = {if_busy_o, if_done_o, inst_o, mem_busy_o, mem_done_o, mem_rdata_o,
                ram_a_o, ram_dout_o, ram_wr_o};
        checks++;
        if (outs !== '0) $display("FAIL idle_after_reset: got %h expected 0", outs);
        else passed++;
    endtask

    task automatic test_word_fetch();
        int done_cyc = 0;
        logic [AW-1:0] exp_a;
        logic [31:0] exp;
        ram[17'h1000] = 8'h13; ram[17'h1001] = 8'h05;
        ram[17'h1002] = 8'h00; ram[17'h1003] = 8'h00;
        @(negedge clk);
        if_i = 1'b1; if_pc_i = 32'h0000_1000;
        if_q.push_back(32'h0000_0513);
        for (int cyc = 1; cyc <= 12 && done_cyc == 0; cyc++) begin
            @(negedge clk);
            if (cyc == 1) if_i = 1'b0;
            if (cyc <= 4) begin
                exp_a = 17'h1000 + AW'(cyc - 1);
                checks++;
                if ({ram_wr_o, ram_a_o} !== {1'b0, exp_a})
                    $display("FAIL fetch_addr_%0d: got wr=%b a=%h expected wr=0 a=%h",
                             cyc, ram_wr_o, ram_a_o, exp_a);
                else passed++;
            end
            if (if_done_o) done_cyc = cyc;
        end
        checks++;
        if (done_cyc != 5) $display("FAIL fetch_latency: got %0d expected 5", done_cyc);
        else passed++;
        checks++;
        if (if_q.size() == 0) $display("FAIL fetch_data: got empty queue expected entry");
        else begin
            exp = if_q.pop_front();
            if (inst_o !== exp) $display("FAIL fetch_data: got %h expected %h", inst_o, exp);
            else passed++;
        end
        @(negedge clk);
        checks++;
        if ({if_done_o, inst_o} !== {1'b0, 32'h0000_0513})
            $display("FAIL fetch_pulse_hold: got done=%b inst=%h expected done=0 inst=00000513",
                     if_done_o, inst_o);
        else passed++;
    endtask

    task automatic test_contention();
        int mem_done_cyc = 0;
        int if_done_cyc = 0;
        bit busy_ok = 1'b1;
        logic [31:0] exp;
        ram[17'h2000] = 8'h78; ram[17'h2001] = 8'h56;
        ram[17'h2002] = 8'h34; ram[17'h2003] = 8'h12;
        @(negedge clk);
        if_i = 1'b1; if_pc_i = 32'h0000_1000;
        mem_i = 1'b1; mem_we_i = 1'b0; mem_len_i = 2'b11; mem_addr_i = 32'h0000_2000;
        mem_q.push_back(32'h1234_5678);
        if_q.push_back(32'h0000_0513);
        #1;
        checks++;
        if ({if_busy_o, mem_busy_o} !== 2'b10)
            $display("FAIL contention_idle_busy: got if=%b mem=%b expected if=1 mem=0",
                     if_busy_o, mem_busy_o);
        else passed++;
        for (int cyc = 1; cyc <= 16 && if_done_cyc == 0; cyc++) begin
            @(negedge clk);
            if (cyc == 1) mem_i = 1'b0;
            if (mem_done_cyc == 0 && !mem_done_o && (if_busy_o !== 1'b1 || if_done_o !== 1'b0))
                busy_ok = 1'b0;
            if (mem_done_o) begin
                mem_done_cyc = cyc;
                checks++;
                if (mem_q.size() == 0) $display("FAIL contention_load: got empty queue expected entry");
                else begin
                    exp = mem_q.pop_front();
                    if (mem_rdata_o !== exp)
                        $display("FAIL contention_load: got %h expected %h", mem_rdata_o, exp);
                    else passed++;
                end
            end
            if (mem_done_cyc != 0 && cyc == mem_done_cyc + 1) begin
                if_i = 1'b0;
                checks++;
                if ({if_busy_o, ram_a_o} !== {1'b1, 17'h1000})
                    $display("FAIL contention_if_grant: got busy=%b a=%h expected busy=1 a=01000",
                             if_busy_o, ram_a_o);
                else passed++;
            end
            if (if_done_o) if_done_cyc = cyc;
        end
        checks++;
        if (busy_ok !== 1'b1) $display("FAIL contention_if_busy: got drop expected held high");
        else passed++;
        checks++;
        if ({mem_done_cyc, if_done_cyc} != {32'd5, 32'd10})
            $display("FAIL contention_order: got mem=%0d if=%0d expected mem=5 if=10",
                     mem_done_cyc, if_done_cyc);
        else passed++;
        checks++;
        if (if_q.size() == 0) $display("FAIL contention_fetch: got empty queue expected entry");
        else begin
            exp = if_q.pop_front();
            if (inst_o !== exp) $display("FAIL contention_fetch: got %h expected %h", inst_o, exp);
            else passed++;
        end
    endtask

    task automatic test_back_to_back();
        int done_cyc = 0;
        int wr_cycles = 0;
        logic [31:0] exp;
        ram[17'h3000] = 8'h11; ram[17'h3001] = 8'h00;
        ram[17'h3002] = 8'h00; ram[17'h3003] = 8'h22;
        @(negedge clk);
        mem_i = 1'b1; mem_we_i = 1'b1; mem_len_i = 2'b01;
        mem_addr_i = 32'h0000_3001; mem_wdata_i = 32'h0000_BEEF;
        for (int cyc = 1; cyc <= 12 && done_cyc == 0; cyc++) begin
            @(negedge clk);
            if (cyc == 1) mem_i = 1'b0;
            if (ram_wr_o) wr_cycles++;
            if (cyc == 1 || cyc == 2) begin
                checks++;
                if ({ram_wr_o, ram_a_o, ram_dout_o} !==
                    {1'b1, (cyc == 1) ? 17'h3001 : 17'h3002, (cyc == 1) ? 8'hEF : 8'hBE})
                    $display("FAIL store_byte_%0d: got wr=%b a=%h d=%h", cyc, ram_wr_o,
                             ram_a_o, ram_dout_o);
                else passed++;
            end
            if (mem_done_o) done_cyc = cyc;
        end
        checks++;
        if ({done_cyc, wr_cycles} != {32'd3, 32'd2})
            $display("FAIL store_timing: got done=%0d wr=%0d expected done=3 wr=2",
                     done_cyc, wr_cycles);
        else passed++;
        // Issue the load in the store's done cycle.
        mem_i = 1'b1; mem_we_i = 1'b0; mem_len_i = 2'b00; mem_addr_i = 32'h0000_3002;
        mem_q.push_back(32'h0000_00BE);
        done_cyc = 0;
        for (int cyc = 1; cyc <= 12 && done_cyc == 0; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                mem_i = 1'b0;
                checks++;
                if (ram_a_o !== 17'h3002)
                    $display("FAIL load_byte_addr: got %h expected 03002", ram_a_o);
                else passed++;
            end
            if (mem_done_o) done_cyc = cyc;
        end
        checks++;
        if (done_cyc != 2) $display("FAIL load_byte_latency: got %0d expected 2", done_cyc);
        else passed++;
        checks++;
        if (mem_q.size() == 0) $display("FAIL load_byte_data: got empty queue expected entry");
        else begin
            exp = mem_q.pop_front();
            if (mem_rdata_o !== exp) $display("FAIL load_byte_data: got %h expected %h", mem_rdata_o, exp);
            else passed++;
        end
        checks++;
        if ({ram[17'h3000], ram[17'h3001], ram[17'h3002], ram[17'h3003]} !== 32'h11EF_BE22)
            $display("FAIL store_ram: got %h%h%h%h expected 11EFBE22", ram[17'h3000],
                     ram[17'h3001], ram[17'h3002], ram[17'h3003]);
        else passed++;
    endtask

    task automatic test_flush();
        int done_cyc = 0;
        bit early_done = 1'b0;
        logic [31:0] exp;
        ram[17'h0100] = 8'h01; ram[17'h0101] = 8'h02; ram[17'h0102] = 8'h03; ram[17'h0103] = 8'h04;
        ram[17'h0200] = 8'hEF; ram[17'h0201] = 8'hBE; ram[17'h0202] = 8'hAD; ram[17'h0203] = 8'hDE;
        @(negedge clk);
        if_i = 1'b1; if_pc_i = 32'h0000_0100;
        for (int cyc = 1; cyc <= 20 && done_cyc == 0; cyc++) begin
            @(negedge clk);
            if (if_done_o) begin
                if (cyc < 10) early_done = 1'b1;
                done_cyc = cyc;
            end
            if (cyc == 3) begin
                checks++;
                if (ram_a_o !== 17'h0102) $display("FAIL flush_point: got %h expected 00102", ram_a_o);
                else passed++;
                flush_i = 1'b1;
            end
            if (cyc == 4) begin
                checks++;
                if ({mem_busy_o, ram_a_o} !== '0)
                    $display("FAIL flush_to_idle: got busy=%b a=%h expected 0", mem_busy_o, ram_a_o);
                else passed++;
            end
            if (cyc == 5) begin
                checks++;
                if ({if_busy_o, ram_a_o, inst_o} !== {1'b0, 17'h0, 32'h0000_0513})
                    $display("FAIL flush_block_grant: got busy=%b a=%h inst=%h", if_busy_o,
                             ram_a_o, inst_o);
                else passed++;
                flush_i = 1'b0; if_pc_i = 32'h0000_0200;
                if_q.push_back(32'hDEAD_BEEF);
            end
            if (cyc == 6) if_i = 1'b0;
        end
        checks++;
        if ({early_done, done_cyc} != {1'b0, 32'd10})
            $display("FAIL flush_refetch_timing: got early=%b done=%0d expected early=0 done=10",
                     early_done, done_cyc);
        else passed++;
        checks++;
        if (if_q.size() == 0) $display("FAIL flush_refetch_data: got empty queue expected entry");
        else begin
            exp = if_q.pop_front();
            if (inst_o !== exp) $display("FAIL flush_refetch_data: got %h expected %h", inst_o, exp);
            else passed++;
        end
    endtask

    task automatic test_wrap();
        int done_cyc = 0;
        logic [AW-1:0] exp_a [4];
        logic [31:0] exp;
        exp_a[0] = 17'h1FFFE; exp_a[1] = 17'h1FFFF; exp_a[2] = 17'h00000; exp_a[3] = 17'h00001;
        ram[17'h1FFFE] = 8'hA1; ram[17'h1FFFF] = 8'hB2; ram[17'h00000] = 8'hC3; ram[17'h00001] = 8'hD4;
        @(negedge clk);
        // Upper address bits must be ignored; flush must not disturb a MEM access.
        flush_i = 1'b1;
        mem_i = 1'b1; mem_we_i = 1'b0; mem_len_i = 2'b10; mem_addr_i = 32'h0003_FFFE;
        mem_q.push_back(32'hD4C3_B2A1);
        for (int cyc = 1; cyc <= 12 && done_cyc == 0; cyc++) begin
            @(negedge clk);
            if (cyc == 1) mem_i = 1'b0;
            if (cyc <= 4) begin
                checks++;
                if (ram_a_o !== exp_a[cyc-1])
                    $display("FAIL wrap_addr_%0d: got %h expected %h", cyc, ram_a_o, exp_a[cyc-1]);
                else passed++;
            end
            if (mem_done_o) done_cyc = cyc;
        end
        flush_i = 1'b0;
        checks++;
        if (done_cyc != 5) $display("FAIL wrap_latency: got %0d expected 5", done_cyc);
        else passed++;
        checks++;
        if (mem_q.size() == 0) $display("FAIL wrap_data: got empty queue expected entry");
        else begin
            exp = mem_q.pop_front();
            if (mem_rdata_o !== exp) $display("FAIL wrap_data: got %h expected %h", mem_rdata_o, exp);
            else passed++;
        end
    endtask

    task automatic test_reset_mid_store();
        logic [102:0] outs;
        for (int i = 0; i < 4; i++) ram[17'h40 + i] = 8'h5A;
        @(negedge clk);
        mem_i = 1'b1; mem_we_i = 1'b1; mem_len_i = 2'b11;
        mem_addr_i = 32'h0000_0040; mem_wdata_i = 32'h4433_2211;
        repeat (3) begin
            @(negedge clk);
            mem_i = 1'b0;
        end
        checks++;
        if ({ram_wr_o, ram_a_o} !== {1'b1, 17'h00042})
            $display("FAIL midstore_third_byte: got wr=%b a=%h expected wr=1 a=00042", ram_wr_o, ram_a_o);
        else passed++;
        rst = 1'b0;
        #1;
        outs = {if_busy_o, if_done_o, inst_o, mem_busy_o, mem_done_o, mem_rdata_o,
                ram_a_o, ram_dout_o, ram_wr_o};
        checks++;
        if (outs !== '0) $display("FAIL midstore_reset_outputs: got %h expected 0", outs);
        else passed++;
        @(negedge clk);
        checks++;
        if ({ram[17'h40], ram[17'h41], ram[17'h42], ram[17'h43]} !== 32'h1122_5A5A)
            $display("FAIL midstore_ram: got %h%h%h%h expected 11225A5A", ram[17'h40],
                     ram[17'h41], ram[17'h42], ram[17'h43]);
        else passed++;
        rst = 1'b1;
        @(negedge clk);
        outs = {if_busy_o, if_done_o, inst_o, mem_busy_o, mem_done_o, mem_rdata_o,
                ram_a_o, ram_dout_o, ram_wr_o};
        checks++;
        if (outs !== '0) $display("FAIL midstore_after_release: got %h expected 0", outs);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_word_fetch();
        test_contention();
        test_back_to_back();
        test_flush();
        test_wrap();
        test_reset_mid_store();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
